// File: rtl/sfp_vec_addsub_pipe.sv
// Two-stage pipelined vector add/subtract on signed fixed-point lanes, with
// optional saturation and per-lane overflow flags / clip event counter.
module sfp_vec_addsub_pipe #(
  parameter int N    = 3,
  parameter int W    = 32,
  parameter int F    = 16,
  parameter int CLIP = 1,
  parameter int CW   = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           in_sub,
  input  logic [N*W-1:0] in_a,
  input  logic [N*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_y,
  output logic [N-1:0]   out_clip,
  output logic [N-1:0]   clip_sticky,
  output logic [CW-1:0]  clip_count,
  input  logic           clr_flags
);

  // F only describes the binary point; the arithmetic is format-agnostic.
  if (F < 0 || F >= W) begin : gBadFormat
    $error("sfp_vec_addsub_pipe: F must satisfy 0 <= F < W");
  end
  if (N < 1) begin : gBadLanes
    $error("sfp_vec_addsub_pipe: N must be at least 1");
  end

  localparam logic [W-1:0]  MaxPos   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MinNeg   = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CountMax = {CW{1'b1}};

  logic                 s1Valid_q, s1Valid_d;
  logic [N*(W+1)-1:0]   s1Sum_q, s1Sum_d;
  logic                 outValid_q, outValid_d;
  logic [N*W-1:0]       outY_q, outY_d;
  logic [N-1:0]         outClip_q, outClip_d;
  logic [N-1:0]         sticky_q, sticky_d;
  logic [CW-1:0]        count_q, count_d;

  logic s1Advance;
  logic s2Advance;
  logic outXfer;

  function automatic logic [W:0] laneSum(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic         sub);
    logic [W:0] aExt;
    logic [W:0] bExt;
    aExt = {a[W-1], a};
    bExt = {b[W-1], b};
    return sub ? (aExt - bExt) : (aExt + bExt);
  endfunction

  function automatic logic laneOvf(input logic [W:0] s);
    return s[W] ^ s[W-1];
  endfunction

  // The sign bit of the exact sum picks the saturation direction.
  function automatic logic [W-1:0] laneResult(input logic [W:0] s);
    logic [W-1:0] r;
    r = s[W-1:0];
    if (CLIP != 0 && laneOvf(s)) begin
      r = s[W] ? MinNeg : MaxPos;
    end
    return r;
  endfunction

  assign s2Advance = !outValid_q || out_ready;
  assign s1Advance = !s1Valid_q || s2Advance;
  assign in_ready  = s1Advance;
  assign outXfer   = outValid_q && out_ready;

  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Sum_d   = s1Sum_q;
    if (s1Advance) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < N; i++) begin
          s1Sum_d[i*(W+1) +: (W+1)] = laneSum(in_a[i*W +: W], in_b[i*W +: W], in_sub);
        end
      end
    end
  end

  // A bubble entering S2 clears the clip flags so out_clip never lingers.
  always_comb begin
    outValid_d = outValid_q;
    outY_d     = outY_q;
    outClip_d  = outClip_q;
    if (s2Advance) begin
      outValid_d = s1Valid_q;
      if (s1Valid_q) begin
        for (int i = 0; i < N; i++) begin
          outY_d[i*W +: W] = laneResult(s1Sum_q[i*(W+1) +: (W+1)]);
          outClip_d[i]     = laneOvf(s1Sum_q[i*(W+1) +: (W+1)]);
        end
      end else begin
        outClip_d = '0;
      end
    end
  end

  // Clear is applied first so a same-cycle flag-setting transfer wins.
  always_comb begin
    sticky_d = clr_flags ? '0 : sticky_q;
    count_d  = clr_flags ? '0 : count_q;
    if (outXfer) begin
      sticky_d = sticky_d | outClip_q;
      if ((|outClip_q) && count_d != CountMax) begin
        count_d = count_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q  <= 1'b0;
      s1Sum_q    <= '0;
      outValid_q <= 1'b0;
      outY_q     <= '0;
      outClip_q  <= '0;
      sticky_q   <= '0;
      count_q    <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Sum_q    <= s1Sum_d;
      outValid_q <= outValid_d;
      outY_q     <= outY_d;
      outClip_q  <= outClip_d;
      sticky_q   <= sticky_d;
      count_q    <= count_d;
    end
  end

  assign out_valid   = outValid_q;
  assign out_y       = outY_q;
  assign out_clip    = outClip_q;
  assign clip_sticky = sticky_q;
  assign clip_count  = count_q;

endmodule

// File: tb/tb_sfp_vec_addsub_pipe.sv
// Directed bench for sfp_vec_addsub_pipe: a saturating and a wrapping
// instance share the same stimulus and handshake.
module tb_sfp_vec_addsub_pipe;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int F  = 8;
  localparam int CW = 4;

  logic           clk;
  logic           rst;
  logic           inValid;
  logic           inSub;
  logic [N*W-1:0] inA;
  logic [N*W-1:0] inB;
  logic           outReady;
  logic           clrFlags;

  logic           inReady,  wInReady;
  logic           outValid, wOutValid;
  logic [N*W-1:0] outY,     wOutY;
  logic [N-1:0]   outClip,  wOutClip;
  logic [N-1:0]   sticky,   wSticky;
  logic [CW-1:0]  count,    wCount;

  int total = 0;
  int bad   = 0;

  sfp_vec_addsub_pipe #(.N(N), .W(W), .F(F), .CLIP(1), .CW(CW)) dutSat (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_sub(inSub),
    .in_a(inA), .in_b(inB),
    .out_valid(outValid), .out_ready(outReady),
    .out_y(outY), .out_clip(outClip),
    .clip_sticky(sticky), .clip_count(count),
    .clr_flags(clrFlags)
  );

  sfp_vec_addsub_pipe #(.N(N), .W(W), .F(F), .CLIP(0), .CW(CW)) dutWrap (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(wInReady), .in_sub(inSub),
    .in_a(inA), .in_b(inB),
    .out_valid(wOutValid), .out_ready(outReady),
    .out_y(wOutY), .out_clip(wOutClip),
    .clip_sticky(wSticky), .clip_count(wCount),
    .clr_flags(clrFlags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one vector, then idle; on return the result sits at the output.
  task automatic applyStimulus(input logic [N*W-1:0] a, input logic [N*W-1:0] b, input logic sub);
    inValid = 1'b1;
    inA     = a;
    inB     = b;
    inSub   = sub;
    step();
    inValid = 1'b0;
    step();
  endtask

  // Reference lane arithmetic done in plain integers, saturating form.
  function automatic logic [50:0] vecModel(input logic [47:0] a, input logic [47:0] b, input logic sub);
    logic [50:0] r;
    int sa, sb, s;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      sa = int'($signed(a[k*16 +: 16]));
      sb = int'($signed(b[k*16 +: 16]));
      s  = sub ? sa - sb : sa + sb;
      if (s > 32767) begin
        r[48+k] = 1'b1;
        r[k*16 +: 16] = 16'h7FFF;
      end else if (s < -32768) begin
        r[48+k] = 1'b1;
        r[k*16 +: 16] = 16'h8000;
      end else begin
        r[k*16 +: 16] = s[15:0];
      end
    end
    return r;
  endfunction

  logic [47:0] strA [6];
  logic [47:0] strB [6];
  logic        strS [6];
  logic [50:0] strE [6];
  bit          pat  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent, got, expCount;
    logic prevStall;
    logic [47:0] prevY;
    logic [2:0]  prevClip;
    logic [15:0] v0, v1, v2;

    rst = 1'b1; inValid = 1'b0; inSub = 1'b0; inA = '0; inB = '0;
    outReady = 1'b1; clrFlags = 1'b0;
    step();
    step();
    checkOutput("reset out_valid", 64'(outValid), 64'd0);
    checkOutput("reset in_ready", 64'(inReady), 64'd1);
    checkOutput("reset out_y", 64'(outY), 64'd0);
    checkOutput("reset sticky", 64'(sticky), 64'd0);
    checkOutput("reset count", 64'(count), 64'd0);
    rst = 1'b0;
    step();

    applyStimulus(48'h0000_0000_0180, 48'h0000_0000_0080, 1'b0);
    checkOutput("add valid", 64'(outValid), 64'd1);
    checkOutput("add y", 64'(outY), 64'h0000_0000_0200);
    checkOutput("add clip", 64'(outClip), 64'd0);
    applyStimulus(48'h0000_0000_0180, 48'h0000_0000_0080, 1'b1);
    checkOutput("sub y", 64'(outY), 64'h0000_0000_0100);
    checkOutput("sub clip", 64'(outClip), 64'd0);
    step();
    checkOutput("noclip count", 64'(count), 64'd0);

    applyStimulus(48'h0000_7F00_0000, 48'h0000_0200_0000, 1'b0);
    checkOutput("sat pos y", 64'(outY), 64'h0000_7FFF_0000);
    checkOutput("sat pos clip", 64'(outClip), 64'b010);
    checkOutput("wrap pos y", 64'(wOutY), 64'h0000_8100_0000);
    checkOutput("wrap pos clip", 64'(wOutClip), 64'b010);
    step();
    checkOutput("sat sticky 1", 64'(sticky), 64'b010);
    checkOutput("sat count 1", 64'(count), 64'd1);

    applyStimulus(48'h8000_0000_0000, 48'h0001_0000_8000, 1'b1);
    checkOutput("sat neg y", 64'(outY), 64'h8000_0000_7FFF);
    checkOutput("sat neg clip", 64'(outClip), 64'b101);
    checkOutput("wrap neg y", 64'(wOutY), 64'h7FFF_0000_8000);
    checkOutput("wrap neg clip", 64'(wOutClip), 64'b101);
    step();
    checkOutput("sat sticky 2", 64'(sticky), 64'b111);
    checkOutput("sat count 2", 64'(count), 64'd2);

    clrFlags = 1'b1;
    step();
    clrFlags = 1'b0;
    checkOutput("clr sticky", 64'(sticky), 64'd0);
    checkOutput("clr count", 64'(count), 64'd0);

    // Backpressure stream with out_ready cycling 1,0,0,1.
    for (int i = 0; i < 6; i++) begin
      v0 = 16'(i * 256);
      v1 = 16'(i * 128);
      v2 = 16'(-i);
      strA[i] = {v2, 16'h7F00, v0};
      strB[i] = {16'(i), v1, 16'h0011};
      strS[i] = (i % 2) == 1;
      strE[i] = vecModel(strA[i], strB[i], strS[i]);
    end
    sent = 0; got = 0; expCount = 0; prevStall = 1'b0; prevY = '0; prevClip = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      outReady = pat[cyc % 4];
      inValid  = sent < 6;
      if (sent < 6) begin
        inA = strA[sent]; inB = strB[sent]; inSub = strS[sent];
      end
      #1;
      if (prevStall) begin
        checkOutput("stall valid hold", 64'(outValid), 64'd1);
        checkOutput("stall y hold", 64'(outY), 64'(prevY));
        checkOutput("stall clip hold", 64'(outClip), 64'(prevClip));
      end
      if (outReady) checkOutput("ready when out_ready", 64'(inReady), 64'd1);
      if (!inReady) checkOutput("not ready implies s2 full", 64'(outValid), 64'd1);
      if (outValid && outReady) begin
        if (got < 6) begin
          checkOutput("stream y", 64'(outY), 64'(strE[got][47:0]));
          checkOutput("stream clip", 64'(outClip), 64'(strE[got][50:48]));
          if (strE[got][50:48] != 3'b000 && expCount < 15) expCount++;
        end
        got++;
      end
      if (inValid && inReady) sent++;
      prevStall = outValid && !outReady;
      prevY     = outY;
      prevClip  = outClip;
      step();
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    checkOutput("stream sent", 64'(sent), 64'd6);
    checkOutput("stream got", 64'(got), 64'd6);
    checkOutput("stream count", 64'(count), 64'(expCount));
    step();
    checkOutput("stream no duplicate", 64'(outValid), 64'd0);

    clrFlags = 1'b1;
    step();
    clrFlags = 1'b0;

    inValid = 1'b1; inA = 48'h0000_7F00_0000; inB = 48'h0000_0200_0000; inSub = 1'b0;
    for (int i = 0; i < 20; i++) step();
    inValid = 1'b0;
    step();
    step();
    checkOutput("count saturate", 64'(count), 64'hF);
    checkOutput("count sticky", 64'(sticky), 64'b010);

    applyStimulus(48'h0000_0000_7FFF, 48'h0000_0000_0001, 1'b0);
    checkOutput("clr race clip", 64'(outClip), 64'b001);
    clrFlags = 1'b1;
    step();
    clrFlags = 1'b0;
    checkOutput("clr race sticky", 64'(sticky), 64'b001);
    checkOutput("clr race count", 64'(count), 64'd1);

    // Fill both stages, then reset mid-stream.
    outReady = 1'b0;
    inValid = 1'b1; inA = 48'h0000_0000_0001; inB = 48'h0000_0000_0001; inSub = 1'b0;
    step();
    step();
    inValid = 1'b0;
    #1;
    checkOutput("full in_ready", 64'(inReady), 64'd0);
    checkOutput("full out_valid", 64'(outValid), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("async rst out_valid", 64'(outValid), 64'd0);
    checkOutput("async rst out_y", 64'(outY), 64'd0);
    checkOutput("async rst clip", 64'(outClip), 64'd0);
    checkOutput("async rst sticky", 64'(sticky), 64'd0);
    checkOutput("async rst count", 64'(count), 64'd0);
    checkOutput("async rst in_ready", 64'(inReady), 64'd1);
    step();
    rst = 1'b0;
    outReady = 1'b1;
    step();
    checkOutput("post rst discarded", 64'(outValid), 64'd0);
    applyStimulus(48'h0000_0000_0123, 48'h0000_0000_0011, 1'b0);
    checkOutput("post rst valid", 64'(outValid), 64'd1);
    checkOutput("post rst y", 64'(outY), 64'h0000_0000_0134);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
